// File: rtl/page_mem_pkg.sv
// Shared types and constants for the paged memory secondary on the multiplexed main bus.
package page_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StTurn,
        StRead,
        StIgnore
    } state_e;

    localparam int unsigned DefaultBurstLen = 4;
    localparam logic [3:0]  DefaultPage     = 4'h2;

    // Page field position within an address-phase word.
    localparam int unsigned PageMsb = 15;
    localparam int unsigned PageLsb = 12;

    typedef logic [15:0] bus_word_t;

endpackage

// File: rtl/page_mem_array.sv
// Word-addressed storage: synchronous write port, combinational read port, no reset.
module page_mem_array
    import page_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  bus_word_t         wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output bus_word_t         rdata_o
);

    bus_word_t mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/page_mem_controller.sv
// Memory-side secondary: claims bursts addressed to its page, stores writes and
// returns reads on the shared AddrData lines.
module page_mem_controller
    import page_mem_pkg::*;
#(
    parameter logic [3:0]  PAGE      = DefaultPage,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BURST_LEN = DefaultBurstLen
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        AddrValid,
    input  logic        rw,
    inout  wire  [15:0] AddrData
);

    localparam int unsigned     CntW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(BURST_LEN - 1);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              turn_q;

    logic      page_hit;
    logic      oe;
    logic      we;
    bus_word_t rdata;

    assign page_hit = (AddrData[PageMsb:PageLsb] == PAGE);
    assign oe       = (state_q == StRead);
    assign we       = (state_q == StWrite);
    assign AddrData = oe ? rdata : 'z;

    // A pending turnaround (turn_q) stretches an ignored read by one cycle so the
    // bus stays quiet for exactly as long as a claimed read would occupy it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            turn_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (AddrValid) begin
                        addr_q <= AddrData[ADDR_W-1:0];
                        cnt_q  <= '0;
                        turn_q <= rw;
                        // An unknown page compare falls through to the miss path.
                        if (page_hit) begin
                            state_q <= rw ? StTurn : StWrite;
                        end else begin
                            state_q <= StIgnore;
                        end
                    end
                end
                StWrite, StRead: begin
                    addr_q <= addr_q + 1'b1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StIdle;
                    end
                end
                StTurn: begin
                    state_q <= StRead;
                end
                StIgnore: begin
                    if (turn_q) begin
                        turn_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastCnt) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    page_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (addr_q),
        .wdata_i (AddrData),
        .raddr_i (addr_q),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_page_mem_controller.sv
// Directed bench for page_mem_controller: write/read bursts, page misses, wrap, reset.
module tb_page_mem_controller;

    logic        clk       = 1'b0;
    logic        resetN    = 1'b0;
    logic        AddrValid = 1'b0;
    logic        rw        = 1'b0;
    logic        tb_en     = 1'b0;
    logic [15:0] tb_data   = 16'h0000;

    // Pulled high so an undriven bus reads as all ones where z is not modelled.
    tri1 [15:0] AddrData;
    assign AddrData = tb_en ? tb_data : 'z;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] rd [4];

    always #5 clk = ~clk;

    page_mem_controller #(
        .PAGE      (4'h2),
        .ADDR_W    (12),
        .BURST_LEN (4)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .AddrValid (AddrValid),
        .rw        (rw),
        .AddrData  (AddrData)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_float(input string tag);
        total++;
        assert (AddrData === 16'hzzzz || AddrData === 16'hffff) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=released", tag, AddrData);
        end
    endtask

    task automatic chk4(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) chk($sformatf("%s_w%0d", tag, i), rd[i], e[i]);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        AddrValid = 1'b0;
        tb_en     = 1'b0;
    endtask

    // pulse_idx >= 0 raises AddrValid alongside that data word.
    task automatic write_burst(input logic [15:0] addr, input logic [15:0] w0,
                               input logic [15:0] w1, input logic [15:0] w2,
                               input logic [15:0] w3, input int pulse_idx);
        logic [15:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        @(negedge clk);
        AddrValid = 1'b1; rw = 1'b0; tb_en = 1'b1; tb_data = addr;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            AddrValid = (i == pulse_idx);
            tb_data   = w[i];
        end
    endtask

    task automatic read_burst(input logic [15:0] addr, input bit expect_drive, input string tag);
        @(negedge clk);
        AddrValid = 1'b1; rw = 1'b1; tb_en = 1'b1; tb_data = addr;
        @(negedge clk);
        AddrValid = 1'b0; rw = 1'b0; tb_en = 1'b0;
        #1 chk_float({tag, "_turn"});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (expect_drive) rd[i] = AddrData;
            else chk_float($sformatf("%s_miss%0d", tag, i));
        end
        @(negedge clk);
        #1 chk_float({tag, "_release"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_float("reset_float");
        @(negedge clk);
        resetN = 1'b1;

        // Basic write then read in page 2.
        write_burst(16'h2000, 16'hABCD, 16'h1234, 16'h5678, 16'h9ABC, -1);
        bus_idle();
        read_burst(16'h2000, 1'b1, "rd2000");
        chk4("rd2000", 16'hABCD, 16'h1234, 16'h5678, 16'h9ABC);

        // Other page: ignored entirely, page 2 contents untouched.
        write_burst(16'h5000, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, -1);
        bus_idle();
        read_burst(16'h5000, 1'b0, "rd5000");
        read_burst(16'h2000, 1'b1, "rd2000b");
        chk4("rd2000b", 16'hABCD, 16'h1234, 16'h5678, 16'h9ABC);

        // Offset wraps inside the page.
        write_burst(16'h2FFE, 16'h1111, 16'h2222, 16'h3333, 16'h4444, -1);
        bus_idle();
        read_burst(16'h2FFE, 1'b1, "rd2ffe");
        chk4("rd2ffe", 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        read_burst(16'h2000, 1'b1, "rdwrap");
        chk4("rdwrap", 16'h3333, 16'h4444, 16'h5678, 16'h9ABC);

        // AddrValid during a data word is not a new address phase.
        write_burst(16'h2100, 16'h0101, 16'h0202, 16'h0303, 16'h0404, -1);
        bus_idle();
        write_burst(16'h2010, 16'h1010, 16'h1011, 16'h2100, 16'h1013, 2);
        bus_idle();
        read_burst(16'h2010, 1'b1, "rd2010");
        chk4("rd2010", 16'h1010, 16'h1011, 16'h2100, 16'h1013);
        read_burst(16'h2100, 1'b1, "rd2100");
        chk4("rd2100", 16'h0101, 16'h0202, 16'h0303, 16'h0404);

        // Reset between write words 1 and 2.
        write_burst(16'h2020, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3, -1);
        bus_idle();
        @(negedge clk);
        AddrValid = 1'b1; rw = 1'b0; tb_en = 1'b1; tb_data = 16'h2020;
        @(negedge clk);
        AddrValid = 1'b0; tb_data = 16'h5050;
        @(negedge clk);
        tb_data = 16'h5151;
        @(negedge clk);
        resetN = 1'b0; tb_en = 1'b0;
        #1 chk_float("rst_wr_float");
        @(negedge clk);
        resetN = 1'b1; tb_en = 1'b1; tb_data = 16'h5252;
        @(negedge clk);
        tb_data = 16'h5353;
        bus_idle();
        read_burst(16'h2020, 1'b1, "rd2020");
        chk4("rd2020", 16'h5050, 16'h5151, 16'hA2A2, 16'hA3A3);

        // Reset in the middle of a read drops the bus immediately.
        @(negedge clk);
        AddrValid = 1'b1; rw = 1'b1; tb_en = 1'b1; tb_data = 16'h2000;
        @(negedge clk);
        AddrValid = 1'b0; rw = 1'b0; tb_en = 1'b0;
        @(negedge clk);
        #1 chk("rst_rd_w0", AddrData, 16'h3333);
        resetN = 1'b0;
        #1 chk_float("rst_rd_float");
        @(negedge clk);
        resetN = 1'b1;

        // Address phase with an undriven bus is a miss.
        @(negedge clk);
        AddrValid = 1'b1; rw = 1'b1; tb_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            AddrValid = 1'b0; rw = 1'b0;
            #1 chk_float($sformatf("zaddr_c%0d", i));
        end

        // Back-to-back write then read, no idle gap.
        write_burst(16'h2040, 16'h4040, 16'h4141, 16'h4242, 16'h4343, -1);
        read_burst(16'h2040, 1'b1, "rd2040");
        chk4("rd2040", 16'h4040, 16'h4141, 16'h4242, 16'h4343);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
